// File: rtl/dnc_write_vector.sv
// dnc_write_vector: responder end of the write-vector START/READY handshake.
// A length-limited stream of elements is captured into a local buffer (LOAD),
// then replayed one element per cycle to the memory-write datapath (EMIT).
module dnc_write_vector #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int W            = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 V_IN_ENABLE,
  output logic                 V_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic [DATA_SIZE-1:0] V_IN,
  output logic [DATA_SIZE-1:0] V_OUT
);

  // Buffer address width, and index width with one extra bit so len=W fits.
  localparam int AW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = (CONTROL_SIZE < AW + 1) ? CONTROL_SIZE : AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [IW-1:0]        len;
  logic [IW-1:0]        load_idx;
  logic [IW-1:0]        emit_idx;
  logic                 ready_q;
  logic                 vld_p1;
  logic [DATA_SIZE-1:0] v_out_p1;
  logic [DATA_SIZE-1:0] buffer [W];

  logic                 accept;
  logic                 cap;
  logic                 emit_fire;
  logic                 emit_done;

  // Requested length clamped to the buffer depth (unsigned compare).
  function automatic logic [IW-1:0] sat_len(input logic [DATA_SIZE-1:0] sz);
    if (sz > DATA_SIZE'(W)) begin
      return IW'(W);
    end
    return sz[IW-1:0];
  endfunction

  // Next-state and per-cycle event decode.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    cap       = 1'b0;
    emit_fire = 1'b0;
    emit_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          accept   = 1'b1;
          // A zero-length request skips LOAD and completes through EMIT.
          state_nx = (sat_len(SIZE_W_IN) == '0) ? S_EMIT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (V_IN_ENABLE) begin
          cap = 1'b1;
          if (load_idx == len - IW'(1)) begin
            state_nx = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (emit_idx < len) begin
          emit_fire = 1'b1;
        end else begin
          emit_done = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state: FSM register, latched length, counters, READY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      len      <= '0;
      load_idx <= '0;
      emit_idx <= '0;
      ready_q  <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_nx;
      vld_p1 <= emit_fire;
      if (accept) begin
        len      <= sat_len(SIZE_W_IN);
        load_idx <= '0;
        emit_idx <= '0;
        ready_q  <= 1'b0;
      end
      if (cap) begin
        load_idx <= load_idx + IW'(1);
      end
      if (emit_fire) begin
        emit_idx <= emit_idx + IW'(1);
      end
      if (emit_done) begin
        ready_q <= 1'b1;
      end
    end
  end

  // Capture stage: element storage, contents survive reset.
  always_ff @(posedge CLK) begin
    if (cap && !RST) begin
      buffer[load_idx[AW-1:0]] <= V_IN;
    end
  end

  // Output stage p1: replayed element, held between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_out_p1 <= '0;
    end else if (emit_fire) begin
      v_out_p1 <= buffer[emit_idx[AW-1:0]];
    end
  end

  assign READY        = ready_q;
  assign V_OUT_ENABLE = vld_p1;
  assign V_OUT        = v_out_p1;

endmodule
